// File: rtl/mod_74x08_quad_tester.sv
// Self-test sequencer for a quad 2-input AND package.
// Walks a 16-step vector schedule across all four gates at once, holds each
// vector for a settle window, then compares Y against A&B. It accumulates a
// per-gate failure mask and a saturating mismatch count, then reports DONE/PASS.

// Single 2-input AND gate (74x08 section). Used here as the golden reference.
module mod_74x08 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// Per-gate checker lane: the reference gate gives the expected value, and any
// difference from the observed gate output is flagged.
module mod_74x08_quad_tester_lane (
  input  logic a,
  input  logic b,
  input  logic y,
  output logic mism
);
  logic exp_y;

  mod_74x08 u_ref (
    .a (a),
    .b (b),
    .y (exp_y)
  );

  assign mism = y ^ exp_y;
endmodule

module mod_74x08_quad_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [3:0]       A,
  output logic [3:0]       B,
  input  logic [3:0]       Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [3:0]       FAIL_MASK,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [3:0]       STEP
);
  localparam int NUM_LANES = 4;
  localparam int SUM_W     = ERR_W + 3;  // headroom so count + 4 never wraps
  localparam int ERR_MAX   = (1 << ERR_W) - 1;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     settle_cnt;
  logic [NUM_LANES-1:0] mism;
  logic [2:0]     pop;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;
  logic [3:0]     mask_nxt;
  logic [3:0]     step_inc;
  logic           last_step;

  // One checker lane per gate; mismatch is only consumed in CHECK.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mod_74x08_quad_tester_lane u_lane (
      .a    (A[i]),
      .b    (B[i]),
      .y    (Y[i]),
      .mism (mism[i])
    );
  end

  // Number of gates that mismatched at this step.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + {2'b00, mism[i]};
  end

  // Saturating accumulate: the sum is formed wide, then clamped at the max.
  always_comb begin
    err_sum = SUM_W'(ERR_COUNT) + SUM_W'(pop);
    if (err_sum > SUM_W'(ERR_MAX)) err_sat = ERR_W'(ERR_MAX);
    else                           err_sat = err_sum[ERR_W-1:0];
  end

  assign mask_nxt  = FAIL_MASK | mism;
  assign step_inc  = STEP + 4'd1;
  assign last_step = (STEP == 4'd15);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: DRIVE(1) -> SETTLE(SETTLE_CYCLES) -> CHECK(1) per step.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = last_step ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: vector registers, settle counter and result accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      A          <= '0;
      B          <= '0;
      PASS       <= 1'b0;
      FAIL_MASK  <= '0;
      ERR_COUNT  <= '0;
      STEP       <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            // Step 0 vector is A=0, B=0; results of the previous run are dropped.
            A         <= '0;
            B         <= '0;
            STEP      <= '0;
            FAIL_MASK <= '0;
            ERR_COUNT <= '0;
            PASS      <= 1'b0;
          end
        end
        S_DRIVE: settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
        S_CHECK: begin
          FAIL_MASK <= mask_nxt;
          ERR_COUNT <= err_sat;
          if (last_step) begin
            // Final verdict includes this last comparison.
            A    <= '0;
            B    <= '0;
            PASS <= (mask_nxt == 4'd0);
          end else begin
            // B is A rotated by two, so gate i sees (s[i], s[(i+2)%4]).
            STEP <= step_inc;
            A    <= step_inc;
            B    <= {step_inc[1:0], step_inc[3:2]};
          end
        end
        default: ;
      endcase
    end
  end

  // Status decoded straight from the state register.
  assign BUSY = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_mod_74x08_quad_tester.sv
// Directed bench for mod_74x08_quad_tester: a cycle-indexed behavioural model
// is checked against two DUT configurations every cycle, plus literal results.
module tb_mod_74x08_quad_tester;
  localparam int P0 = 4, T0 = 64, EMAX0 = 127;  // SETTLE=2, ERR_W=7
  localparam int P1 = 3, T1 = 48, EMAX1 = 7;    // SETTLE=1, ERR_W=3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic [3:0] a0, b0, y0, mask0, step0;
  logic [3:0] a1, b1, y1, mask1, step1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] err0;
  logic [2:0] err1;

  // Fault injection on the gate outputs: stuck-at-1, stuck-at-0, invert.
  logic [3:0] sa1_0, sa0_0;
  logic       inv_0, inv_1;
  assign y0 = (((a0 & b0) | sa1_0) & ~sa0_0) ^ {4{inv_0}};
  assign y1 = (a1 & b1) ^ {4{inv_1}};

  mod_74x08_quad_tester u_dut0 (
    .CLK(clk), .RST(rst), .START(start0), .A(a0), .B(b0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_MASK(mask0),
    .ERR_COUNT(err0), .STEP(step0)
  );

  mod_74x08_quad_tester #(.SETTLE_CYCLES(1), .ERR_W(3)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_MASK(mask1),
    .ERR_COUNT(err1), .STEP(step1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Mask/count after the first n steps of a run under a given fault.
  function automatic void acc_model(input int n, input logic [3:0] sa1, input logic [3:0] sa0,
                                    input logic inv, input int emax,
                                    output logic [3:0] m, output int c);
    m = '0;
    c = 0;
    for (int s = 0; s < n; s++) begin
      logic [3:0] va, vb, e, y, mm;
      va = 4'(s);
      vb = {va[1:0], va[3:2]};
      e  = va & vb;
      y  = ((e | sa1) & ~sa0) ^ {4{inv}};
      mm = y ^ e;
      m  = m | mm;
      c  = c + $countones(mm);
      if (c > emax) c = emax;
    end
  endfunction

  // Expected outputs in cycle t after the START-accepting edge (t<0: reset/never run).
  task automatic model_chk(input string id, input int t, input int p, input int emax,
                           input logic [3:0] sa1, input logic [3:0] sa0, input logic inv,
                           input logic busy, input logic done, input logic pass,
                           input logic [3:0] mask, input logic [3:0] step,
                           input logic [3:0] a, input logic [3:0] b, input logic [31:0] err);
    logic [3:0] em, es, ea, eb;
    int ec;
    logic ebusy, edone, epass;
    if (t < 0) begin
      em = 0; ec = 0; es = 0; ea = 0; eb = 0; ebusy = 0; edone = 0; epass = 0;
    end else if (t < 16 * p) begin
      es = 4'(t / p); ea = es; eb = {es[1:0], es[3:2]};
      ebusy = 1; edone = 0; epass = 0;
      acc_model(t / p, sa1, sa0, inv, emax, em, ec);
    end else begin
      acc_model(16, sa1, sa0, inv, emax, em, ec);
      es = 4'd15; ea = 0; eb = 0; ebusy = 0;
      edone = (t == 16 * p);
      epass = (em == 4'd0);
    end
    chk({id, ".busy"}, busy, ebusy);
    chk({id, ".done"}, done, edone);
    chk({id, ".pass"}, pass, epass);
    chk({id, ".mask"}, mask, em);
    chk({id, ".step"}, step, es);
    chk({id, ".a"}, a, ea);
    chk({id, ".b"}, b, eb);
    chk({id, ".err"}, err, ec);
  endtask

  // Model time base: fault config is latched when a run is accepted.
  int t0 = -1, t1 = -1;
  logic armed = 1'b0;
  logic [3:0] r_sa1, r_sa0;
  logic r_inv0, r_inv1;

  always @(posedge clk) begin
    if (rst) begin
      t0 <= -1;
      armed <= 1'b1;
    end else if ((t0 < 0 || t0 > T0) && start0) begin
      t0 <= 0; r_sa1 <= sa1_0; r_sa0 <= sa0_0; r_inv0 <= inv_0;
    end else if (t0 >= 0) t0 <= t0 + 1;
  end

  always @(posedge clk) begin
    if (rst) t1 <= -1;
    else if ((t1 < 0 || t1 > T1) && start1) begin
      t1 <= 0; r_inv1 <= inv_1;
    end else if (t1 >= 0) t1 <= t1 + 1;
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (armed) begin
      model_chk("d0", t0, P0, EMAX0, r_sa1, r_sa0, r_inv0,
                busy0, done0, pass0, mask0, step0, a0, b0, {25'd0, err0});
      model_chk("d1", t1, P1, EMAX1, 4'd0, 4'd0, r_inv1,
                busy1, done1, pass1, mask1, step1, a1, b1, {29'd0, err1});
    end
  end

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Start a run and count cycles until DONE; cycle 0 follows the accepting edge.
  task automatic run(input int sel, output int cyc);
    pulse_start(sel);
    cyc = 0;
    while (((sel == 0) ? done0 : done1) !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL run%0d.timeout: no DONE within %0d cycles", sel, cyc);
    end
  endtask

  task automatic wait_step0(input logic [3:0] s);
    int n = 0;
    while (step0 !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_step.timeout: STEP=%0d never reached %0d", step0, s);
    end
  endtask

  initial begin
    int cyc;
    int sawdone;
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    sa1_0 = '0; sa0_0 = '0; inv_0 = 1'b0; inv_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy0, 0);
    chk("rst.step", step0, 0);
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst.idle", busy0, 0);

    // Good device.
    run(0, cyc);
    chk("good.cycles", cyc, 64);
    chk("good.pass", pass0, 1);
    chk("good.err", err0, 0);
    chk("good.mask", mask0, 4'b0000);
    chk("good.step", step0, 15);

    // Y[2] stuck-at-1.
    sa1_0 = 4'b0100;
    run(0, cyc);
    chk("sa1.err", err0, 12);
    chk("sa1.mask", mask0, 4'b0100);
    chk("sa1.pass", pass0, 0);

    // Y[0] stuck-at-0, then a good device clears the previous result.
    sa1_0 = 4'b0000; sa0_0 = 4'b0001;
    run(0, cyc);
    chk("sa0.err", err0, 4);
    chk("sa0.mask", mask0, 4'b0001);
    chk("sa0.pass", pass0, 0);
    sa0_0 = 4'b0000;
    run(0, cyc);
    chk("clear.pass", pass0, 1);
    chk("clear.err", err0, 0);

    // START mid-run is ignored.
    pulse_start(0);
    wait_step0(4'd5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("midstart.done", done0, 1);
    chk("midstart.pass", pass0, 1);

    // Reset mid-run on a faulty device aborts without a DONE pulse.
    repeat (3) @(negedge clk);
    sa1_0 = 4'b0100;
    pulse_start(0);
    wait_step0(4'd7);
    chk("prerst.err", (err0 != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", busy0, 0);
    chk("midrst.a", a0, 0);
    chk("midrst.b", b0, 0);
    chk("midrst.err", err0, 0);
    sawdone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done0 === 1'b1) sawdone = 1;
    end
    chk("midrst.nodone", sawdone, 0);
    sa1_0 = 4'b0000;

    // Narrow counter saturates; every step fully inverted.
    inv_1 = 1'b1;
    run(1, cyc);
    chk("sat.cycles", cyc, 48);
    chk("sat.err", err1, 7);
    chk("sat.mask", mask1, 4'b1111);
    chk("sat.pass", pass1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_74x08_quad_tester.md
Name: mod_74x08_quad_tester

Overview:
- Self-test sequencer for a quad 2-input AND package, built from four instances of the 74x08 single-gate model.
- On START, walks a fixed 16-step vector schedule across all four gates at once and drives the gate A/B inputs.
- After a settle window, samples Y and compares it with A&B.
- Accumulates a per-gate failure mask and a mismatch count; reports DONE/PASS.
- Sits between a bench/host controller and the gate datapath under test.

Parameters:
- SETTLE_CYCLES, 2, cycles held in SETTLE before Y is sampled; legal range 1..255.
- ERR_W, 7, width of ERR_COUNT; the counter saturates at 2^ERR_W-1.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  level sampled on CLK; starts a run when in IDLE.
- A  output  4  gate A inputs, bit i drives gate i.
- B  output  4  gate B inputs, bit i drives gate i.
- Y  input  4  gate outputs, bit i from gate i.
- BUSY  output  1  high while a run is in progress (DRIVE/SETTLE/CHECK).
- DONE  output  1  one-cycle pulse at end of run.
- PASS  output  1  result of last completed run; held until next START accepted.
- FAIL_MASK  output  4  bit i set if gate i mismatched at any step of the current/last run.
- ERR_COUNT  output  ERR_W  total mismatched bits over the run, saturating.
- STEP  output  4  current step index s.

Behaviour:
- One clock domain: CLK. Reset is synchronous and active-high: RST.
- Reset values: state=IDLE, A=0, B=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, ERR_COUNT=0, STEP=0, settle counter=0.
- RST overrides everything, including mid-run; reset values apply on the next edge.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- Vector for step s (0..15): A=s; B={s[1:0],s[3:2]}.
  - Gate i therefore sees (s[i], s[(i+2)%4]).
  - Every gate sees all four input combinations four times each.
  - Expected output E = A & B.
- IDLE + START=1 at an edge:
  - next state DRIVE.
  - STEP=0; A/B loaded with step-0 vector (both 0).
  - FAIL_MASK, ERR_COUNT and PASS cleared.
- START is ignored outside IDLE. It is level-sensitive, so START held high re-triggers a run when the FSM returns to IDLE.
- DRIVE: 1 cycle, then SETTLE with counter=0.
- SETTLE: held SETTLE_CYCLES cycles, then CHECK.
- CHECK: 1 cycle. On its closing edge:
  - mismatch M = Y ^ E (registered A/B).
  - FAIL_MASK |= M.
  - ERR_COUNT += popcount(M), saturating at 2^ERR_W-1 with no wrap.
  - If STEP<15: STEP+1, next vector loaded into A/B, go to DRIVE.
  - If STEP=15: go to DONE; A=B=0.
- A/B are stable for the whole step: SETTLE_CYCLES+2 cycles.
- DONE state (1 cycle):
  - DONE=1; PASS = (FAIL_MASK==0), using the final mask including the last CHECK.
  - BUSY=0; then IDLE.
- DONE is high exactly 16*(SETTLE_CYCLES+2) cycles after the START-accepting edge (64 with default).
- BUSY=1 in DRIVE/SETTLE/CHECK only.
- STEP holds 15 after completion until the next run or reset.
- Y is sampled only at the CHECK closing edge; Y values at all other times are don't-care.

Test Plan:
- Reset: assert RST 2 cycles with START=1 -> all outputs at reset values; no run starts while RST=1.
- Good device (four working AND gates), default params: START pulse -> BUSY high 64 cycles, DONE pulse at cycle 64, PASS=1, FAIL_MASK=0000, ERR_COUNT=0, STEP=15.
- Y[2] stuck-at-1 -> E[2]=1 in 4 of 16 steps, so ERR_COUNT=12; FAIL_MASK=0100; PASS=0.
- Y[0] stuck-at-0 -> ERR_COUNT=4, FAIL_MASK=0001, PASS=0. Then restart with a good device -> PASS=1, ERR_COUNT=0 (clear on START verified).
- START pulsed at step 5 mid-run -> ignored; run completes normally. Then RST at step 7 -> next cycle BUSY=0, A=B=0, ERR_COUNT=0, no DONE pulse.
- ERR_W=3, Y forced to ~E every step (64 mismatches) -> ERR_COUNT saturates at 7 with no wrap; FAIL_MASK=1111; SETTLE_CYCLES=1 gives DONE at cycle 48.
